rr_arbiter_4: RTL

//  4-requester round-robin arbiter. Shares one resource among four requesters.
//  The winning 2-bit index drives a 2-to-4 enable decoder, which produces the one-hot grant.

---
 rtl/arb_pkg.sv | 36 +++
 rtl/dec2to4_en.sv | 27 ++
 rtl/rr_arbiter_4.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the 4-requester round-robin arbiter:
//   N_REQ   number of requesters
//   IDX_W   width of a requester index
//   state_t arbiter FSM state (IDLE / BUSY)
//   rr_pick round-robin winner search starting at a priority pointer
// -----------------------------------------------------------------------------
package arb_pkg;

   localparam int N_REQ = 4;
   localparam int IDX_W = 2;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // First asserted request scanning ptr, ptr+1, ... (index wraps naturally in
   // IDX_W bits). Returns ptr when nothing is requested; callers gate on req!=0.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                input logic [IDX_W-1:0] ptr);
      logic [IDX_W-1:0] cand;
      logic             found;
      logic             hit;
      rr_pick = ptr;
      found   = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         cand    = ptr + IDX_W'(i);
         hit     = ~found & req[cand];
         rr_pick = hit ? cand : rr_pick;
         found   = found | hit;
      end
   endfunction

endpackage

// File: rtl/dec2to4_en.sv
// -----------------------------------------------------------------------------
// dec2to4_en
// 2-to-4 decoder with enable; output is one-hot when enabled, zero otherwise.
// Ports:
//   idx_i  [IDX_W-1:0]  index to decode
//   en_i                decoder enable
//   dec_o  [N_REQ-1:0]  one-hot (or all-zero) output
// -----------------------------------------------------------------------------
module dec2to4_en
   import arb_pkg::*;
(
   input  logic [IDX_W-1:0] idx_i,
   input  logic             en_i,
   output logic [N_REQ-1:0] dec_o
);

   // Decode the index into a single set bit, only while enabled.
   always_comb begin
      dec_o = '0;
      if (en_i) begin
         dec_o[idx_i] = 1'b1;
      end else begin
         dec_o = '0;
      end
   end

endmodule

// File: rtl/rr_arbiter_4.sv
// -----------------------------------------------------------------------------
// rr_arbiter_4
// Four-requester round-robin arbiter with a hold timer that bounds how long a
// single owner keeps the resource while others are waiting.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req        [3:0] level-sensitive requests
//   gnt        [3:0] registered one-hot grant, zero when idle
//   gnt_valid  high while a grant is active
//   gnt_idx    [1:0] current owner index (meaningful when gnt_valid=1)
// Parameters:
//   MAX_HOLD   max consecutive cycles one owner holds while others request
//   HOLD_W     hold counter width (MAX_HOLD <= 2**HOLD_W-1)
// -----------------------------------------------------------------------------
module rr_arbiter_4
   import arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 8,
   parameter int unsigned HOLD_W   = 8
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic             gnt_valid,
   output logic [IDX_W-1:0] gnt_idx
);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   state_t             state_q,    state_d;
   logic [IDX_W-1:0]   ptr_q,      ptr_d;
   logic [IDX_W-1:0]   idx_q,      idx_d;
   logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
   logic               valid_q,    valid_d;
   logic [N_REQ-1:0]   gnt_q;

   logic [IDX_W-1:0]   win_s;
   logic [N_REQ-1:0]   owner_mask_s;
   logic [N_REQ-1:0]   others_s;
   logic               owner_req_s;
   logic               issue_s;
   logic [N_REQ-1:0]   gnt_dec_s;

   // Winner candidate and the view of the current owner versus everyone else.
   always_comb begin
      win_s        = rr_pick(req, ptr_q);
      owner_mask_s = {{(N_REQ-1){1'b0}}, 1'b1} << idx_q;
      owner_req_s  = |(req & owner_mask_s);
      others_s     = req & ~owner_mask_s;
   end

   // Next-state logic: decides when a new grant is issued and advances the
   // hold counter while the owner keeps the resource.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      idx_d      = idx_q;
      hold_cnt_d = hold_cnt_q;
      issue_s    = 1'b0;

      case (state_q)
         IDLE: begin
            if (req != {N_REQ{1'b0}}) begin
               issue_s = 1'b1;
            end else begin
               state_d    = IDLE;
               hold_cnt_d = {HOLD_W{1'b0}};
            end
         end
         BUSY: begin
            if (!owner_req_s) begin
               // Owner released: hand over without a dead cycle if anyone waits.
               if (others_s != {N_REQ{1'b0}}) begin
                  issue_s = 1'b1;
               end else begin
                  state_d    = IDLE;
                  hold_cnt_d = {HOLD_W{1'b0}};
               end
            end else if ((others_s != {N_REQ{1'b0}}) && (hold_cnt_q == HOLD_LAST)) begin
               // Forced switch. ptr already points past the owner, so the
               // owner is scanned last and another requester wins.
               issue_s = 1'b1;
            end else if (hold_cnt_q == HOLD_LAST) begin
               hold_cnt_d = hold_cnt_q;
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end
         default: begin
            state_d    = IDLE;
            hold_cnt_d = {HOLD_W{1'b0}};
         end
      endcase

      if (issue_s) begin
         state_d    = BUSY;
         idx_d      = win_s;
         ptr_d      = win_s + IDX_W'(1);
         hold_cnt_d = {HOLD_W{1'b0}};
      end else begin
         ptr_d = ptr_d;
      end
   end

   assign valid_d = (state_d == BUSY);

   // Decode the next owner so the one-hot grant can be registered directly;
   // gnt and gnt_valid then change on the same edge and never disagree.
   dec2to4_en u_gnt_dec (
      .idx_i (idx_d),
      .en_i  (valid_d),
      .dec_o (gnt_dec_s)
   );

   // State, pointer, hold counter and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= {IDX_W{1'b0}};
         idx_q      <= {IDX_W{1'b0}};
         hold_cnt_q <= {HOLD_W{1'b0}};
         valid_q    <= 1'b0;
         gnt_q      <= {N_REQ{1'b0}};
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         idx_q      <= idx_d;
         hold_cnt_q <= hold_cnt_d;
         valid_q    <= valid_d;
         gnt_q      <= gnt_dec_s;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_valid = valid_q;
   assign gnt_idx   = idx_q;

endmodule
